// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-binary conversion path.
//   state_e   : conversion FSM states
//   DIGIT_W   : width of one BCD digit
//   MAX_DIGIT : largest legal BCD digit value
//   DEF_LIMIT : display-range threshold shared with the binary-to-BCD path
package bcd_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;
    localparam int DEF_LIMIT = 640;

endpackage

// File: rtl/mul10_add.sv
// Combinational multiply-by-ten and add one digit: res = acc*10 + digit.
//   acc   : running accumulator (WIDTH bits)
//   digit : next BCD digit (DIGIT_W bits)
//   res   : new accumulator value, truncated to WIDTH bits
module mul10_add #(
    parameter int WIDTH   = 10,
    parameter int DIGIT_W = 4
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [DIGIT_W-1:0] digit,
    output logic [WIDTH-1:0]   res
);

    // acc*10 built from two shifts, kept 4 bits wider than the accumulator
    // so no carry is dropped before the final truncation.
    logic [WIDTH+3:0] acc_w;
    logic [WIDTH+3:0] sum;
    logic             unused_hi;

    assign acc_w     = {4'b0000, acc};
    assign sum       = (acc_w << 3) + (acc_w << 1) + {{(WIDTH+4-DIGIT_W){1'b0}}, digit};
    assign res       = sum[WIDTH-1:0];
    assign unused_hi = ^sum[WIDTH+3:WIDTH];

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter, one digit per cycle, MSD first.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake for digits bcd2..bcd0
//   out_valid/out_ready : output handshake for number/err/ovf
//   number              : binary value (0 when err)
//   err                 : some captured digit was above 9
//   ovf                 : number >= LIMIT (only when err=0)
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 3,
    parameter int WIDTH   = 10,
    parameter int LIMIT   = DEF_LIMIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       bcd0,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] number,
    output logic             err,
    output logic             ovf
);

    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    state_e                            state_q, state_d;
    logic [NDIGITS-1:0][DIGIT_W-1:0]   dig_q, dig_d;
    logic [NDIGITS-1:0][DIGIT_W-1:0]   cap_dig;
    logic [WIDTH-1:0]                  acc_q, acc_d;
    logic [IDXW-1:0]                   idx_q, idx_d;
    logic                              bad_q, bad_d;
    logic [WIDTH-1:0]                  number_q, number_d;
    logic                              err_q, err_d;
    logic                              ovf_q, ovf_d;
    logic [WIDTH-1:0]                  mac;
    logic                              cap_bad;

    // Map the fixed digit ports onto the NDIGITS-wide latch; digit
    // positions beyond the three ports read as zero.
    for (genvar i = 0; i < NDIGITS; i++) begin : g_cap
        if (i == 0) begin : g_d0
            assign cap_dig[i] = bcd0;
        end else if (i == 1) begin : g_d1
            assign cap_dig[i] = bcd1;
        end else if (i == 2) begin : g_d2
            assign cap_dig[i] = bcd2;
        end else begin : g_dz
            assign cap_dig[i] = '0;
        end
    end

    always_comb begin
        cap_bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (cap_dig[i] > DIGIT_W'(MAX_DIGIT)) cap_bad = 1'b1;
        end
    end

    mul10_add #(
        .WIDTH  (WIDTH),
        .DIGIT_W(DIGIT_W)
    ) u_mac (
        .acc  (acc_q),
        .digit(dig_q[idx_q]),
        .res  (mac)
    );

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        bad_d    = bad_q;
        number_d = number_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CONV;
                    dig_d   = cap_dig;
                    acc_d   = '0;
                    idx_d   = IDXW'(NDIGITS - 1);
                    bad_d   = cap_bad;
                end
            end
            S_CONV: begin
                acc_d = mac;
                idx_d = idx_q - 1'b1;
                // Last digit: publish the result in the same edge.
                if (idx_q == '0) begin
                    state_d  = S_DONE;
                    number_d = bad_q ? '0 : mac;
                    err_d    = bad_q;
                    ovf_d    = !bad_q && (mac >= WIDTH'(LIMIT));
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dig_q    <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            bad_q    <= 1'b0;
            number_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            bad_q    <= bad_d;
            number_q <= number_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign number    = number_q;
    assign err       = err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: vector table, back-pressure hold,
// mid-conversion reset and a 0..999 round trip through a bin-to-BCD model.
module tb_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] bcd0, bcd1, bcd2;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] number;
    logic       err;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_to_bin #(.NDIGITS(3), .WIDTH(10), .LIMIT(640)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .bcd0     (bcd0),
        .bcd1     (bcd1),
        .bcd2     (bcd2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .number   (number),
        .err      (err),
        .ovf      (ovf)
    );

    typedef struct {
        logic [3:0] d2, d1, d0;
        int         num;
        logic       e;
        logic       o;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; checks exact latency, result and release.
    task automatic do_conv(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                           input int num, input logic e, input logic o, input string tag);
        chk({tag, " in_ready"}, int'(in_ready), 1);
        bcd2 = d2; bcd1 = d1; bcd0 = d0;
        in_valid = 1'b1;
        step();                     // accept edge T
        in_valid = 1'b0;
        bcd2 = ~d2; bcd1 = ~d1; bcd0 = ~d0;   // must not leak into result
        chk({tag, " busy"}, int'(in_ready), 0);
        for (int k = 1; k <= 2; k++) begin
            chk($sformatf("%s early_valid@T+%0d", tag, k - 1), int'(out_valid), 0);
            step();
        end
        chk({tag, " early_valid@T+2"}, int'(out_valid), 0);
        step();                     // edge T+3
        chk({tag, " out_valid"}, int'(out_valid), 1);
        chk({tag, " number"}, int'(number), num);
        chk({tag, " err"}, int'(err), int'(e));
        chk({tag, " ovf"}, int'(ovf), int'(o));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, " back_idle"}, int'(in_ready), 1);
        chk({tag, " valid_drop"}, int'(out_valid), 0);
    endtask

    vec_t vt[$];

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        bcd0 = '0; bcd1 = '0; bcd2 = '0;

        vt.push_back('{4'd3, 4'd9, 4'd9, 399, 1'b0, 1'b0});
        vt.push_back('{4'd7, 4'd2, 4'd5, 725, 1'b0, 1'b1});
        vt.push_back('{4'd6, 4'd4, 4'd0, 640, 1'b0, 1'b1});
        vt.push_back('{4'd6, 4'd3, 4'd9, 639, 1'b0, 1'b0});
        vt.push_back('{4'd0, 4'hA, 4'd1,   0, 1'b1, 1'b0});
        vt.push_back('{4'd0, 4'd0, 4'd0,   0, 1'b0, 1'b0});
        vt.push_back('{4'd9, 4'd9, 4'd9, 999, 1'b0, 1'b1});
        vt.push_back('{4'd1, 4'd0, 4'd0, 100, 1'b0, 1'b0});
        vt.push_back('{4'd0, 4'd0, 4'd9,   9, 1'b0, 1'b0});
        vt.push_back('{4'hF, 4'd0, 4'd0,   0, 1'b1, 1'b0});
        vt.push_back('{4'd9, 4'hA, 4'd9,   0, 1'b1, 1'b0});
        vt.push_back('{4'd9, 4'd9, 4'hC,   0, 1'b1, 1'b0});

        // reset state
        #12;
        chk("rst in_ready", int'(in_ready), 1);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst number", int'(number), 0);
        chk("rst err", int'(err), 0);
        chk("rst ovf", int'(ovf), 0);
        step();
        rst_n = 1'b1;
        step();

        foreach (vt[i])
            do_conv(vt[i].d2, vt[i].d1, vt[i].d0, vt[i].num, vt[i].e, vt[i].o,
                    $sformatf("vec%0d", i));

        // back-pressure: hold DONE for 5 cycles with in_valid pulses
        bcd2 = 4'd4; bcd1 = 4'd5; bcd0 = 4'd6; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        chk("hold enter", int'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            bcd2 = 4'd1; bcd1 = 4'd1; bcd0 = 4'd1;
            step();
            chk($sformatf("hold%0d valid", k), int'(out_valid), 1);
            chk($sformatf("hold%0d number", k), int'(number), 456);
            chk($sformatf("hold%0d in_ready", k), int'(in_ready), 0);
            chk($sformatf("hold%0d ovf", k), int'(ovf), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("hold release idle", int'(in_ready), 1);
        chk("hold release valid", int'(out_valid), 0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("no_ghost%0d", k), int'(out_valid), 0);
        end

        // reset in the middle of CONV (number still holds 456)
        bcd2 = 4'd7; bcd1 = 4'd2; bcd0 = 4'd5; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst in_ready", int'(in_ready), 1);
        chk("midrst number", int'(number), 0);
        chk("midrst out_valid", int'(out_valid), 0);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("midrst no_valid%0d", k), int'(out_valid), 0);
        end
        do_conv(4'd0, 4'd0, 4'd0, 0, 1'b0, 1'b0, "post_rst");

        // round trip through a bin-to-BCD model that flags >= 640 with 0xF digits
        for (int v = 0; v < 1000; v++) begin
            logic [3:0] h, t, u;
            if (v < 640) begin
                h = 4'(v / 100); t = 4'((v / 10) % 10); u = 4'(v % 10);
                do_conv(h, t, u, v, 1'b0, 1'b0, $sformatf("rt%0d", v));
            end else begin
                h = 4'hF; t = 4'hF; u = 4'hF;
                do_conv(h, t, u, 0, 1'b1, 1'b0, $sformatf("rt%0d", v));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
